sdpb_sample_fifo: RTL and testbench
===================================

SDPB_SAMPLE_FIFO -- requirements
Module: sdpb_sample_fifo

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, sample word width in bits (1..36).
REQ-002 SHALL provide parameter ADDR_W, default 11, log2 of depth; DEPTH = 2^ADDR_W words (2048 default).
REQ-003 SHALL provide parameter READ_MODE, default 0; 0 = bypass (read latency 1), 1 = pipeline output register (read latency 2).
REQ-004 SHALL provide parameter AFULL_TH, default 1536, almost-full threshold in words.
REQ-005 SHALL provide parameter AEMPTY_TH, default 512, almost-empty threshold in words.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 flush  input  1  synchronous clear of contents, same effect as reset except for sticky flags.
REQ-009 wr_en  input  1  write request.
REQ-010 din  input  DATA_W  write data.
REQ-011 rd_en  input  1  read request.
REQ-012 dout  output  DATA_W  read data.
REQ-013 dout_vld  output  1  one-cycle strobe, dout holds a newly read word.
REQ-014 full / empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-015 afull / aempty  output  1 each  occupancy >= AFULL_TH / occupancy <= AEMPTY_TH.
REQ-016 count  output  ADDR_W+1  current occupancy in words.
REQ-017 ovf / udf  output  1 each  sticky overflow / underflow flags.
REQ-018 clr_flags  input  1  clears ovf and udf.

Function
REQ-019 Storage SHALL be one simple dual-port array, write port ADDR_W-bit wr_ptr, read port ADDR_W-bit rd_ptr, inferable as block RAM.
REQ-020 Write accepted iff wr_en=1 and full=0; din stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-021 Read accepted iff rd_en=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-022 Accept decisions SHALL use registered full/empty of the current cycle: when full, write rejected even with a simultaneous accepted read; when empty, read rejected even with a simultaneous accepted write.
REQ-023 count: +1 on write-only accept, -1 on read-only accept, unchanged when both or neither accepted; count never exceeds DEPTH nor drops below 0.
REQ-024 full, empty, afull, aempty SHALL be registered and consistent with count in the same cycle.
REQ-025 READ_MODE=0: accepted read in cycle N -> dout valid, dout_vld=1 in cycle N+1.
REQ-026 READ_MODE=1: accepted read in cycle N -> dout valid, dout_vld=1 in cycle N+2; back-to-back reads SHALL stream one word per cycle.
REQ-027 dout SHALL hold its last value when dout_vld=0.
REQ-028 A read of the word written in the same cycle is impossible (REQ-022); a word written in cycle N is readable from cycle N+1.
REQ-029 ovf set on wr_en=1 with full=1; udf set on rd_en=1 with empty=1; both remain set until clr_flags or reset; set condition wins over simultaneous clr_flags.
REQ-030 flush: next cycle wr_ptr=rd_ptr=0, count=0, empty=1, full=0, afull=0, aempty=1, in-flight read pipeline cancelled (dout_vld=0), dout held, ovf/udf unchanged; wr_en/rd_en ignored in the flush cycle.
REQ-031 Pointer wrap from DEPTH-1 to 0 SHALL be seamless with no data loss or extra latency.

Reset
REQ-032 On reset=1 at a clock edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, aempty=1, full=0, afull=0, dout=0, dout_vld=0, ovf=0, udf=0, pipeline stage cleared.
REQ-033 Reset SHALL override flush, wr_en, rd_en, clr_flags; memory array contents need not be cleared.
REQ-034 Reset asserted mid-stream SHALL cancel pending dout_vld strobes.

Verification
REQ-035 Defaults, READ_MODE=0: write 0x0001..0x0004, then read 4 in consecutive cycles -> dout 0x0001..0x0004 on consecutive cycles one cycle after each rd_en, count 4->0, empty=1 at end.
REQ-036 Fill 2048 words -> full=1, afull=1 from count 1536; extra wr_en -> ovf=1, count stays 2048; clr_flags -> ovf=0.
REQ-037 READ_MODE=1, 3 stored words, rd_en held 3 cycles from cycle N -> dout_vld in N+2..N+4 with correct order; 4th rd_en -> udf=1, no dout_vld.
REQ-038 count=1000, simultaneous wr_en and rd_en for 5000 cycles (wraps pointers) -> count stays 1000, read data equals written data delayed by 1000 samples.
REQ-039 count=100 with read in flight, assert flush -> next cycle count=0, empty=1, no dout_vld; ovf/udf unchanged.
REQ-040 Assert reset with full=1, ovf=1 -> next cycle count=0, empty=1, full=0, ovf=0, dout=0.

Source files
------------

// File: rtl/sdpb_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sdpb_sample_fifo
// Description : Single-clock sample FIFO built on one simple dual-port RAM.
//               Registered full/empty/afull/aempty flags, occupancy count,
//               sticky overflow/underflow flags and a selectable read
//               latency (1 = RAM output direct, 2 = extra output register).
// Revision    : 1.0 - initial release
// ============================================================================
module sdpb_sample_fifo #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 11,
   parameter int READ_MODE = 0,
   parameter int AFULL_TH  = 1536,
   parameter int AEMPTY_TH = 512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld,
   output logic              full,
   output logic              empty,
   output logic              afull,
   output logic              aempty,
   output logic [ADDR_W:0]   count,
   output logic              ovf,
   output logic              udf,
   input  logic              clr_flags
);

   localparam int              DEPTH        = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] c_depth      = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] c_afull_th   = (ADDR_W+1)'(AFULL_TH);
   localparam logic [ADDR_W:0] c_aempty_th  = (ADDR_W+1)'(AEMPTY_TH);

   // Storage: no reset so the array maps onto block RAM.
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_full;
   logic              r_empty;
   logic              r_afull;
   logic              r_aempty;
   logic              r_ovf;
   logic              r_udf;
   logic [DATA_W-1:0] r_dout;
   logic              r_dout_vld;

   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_ovf_set;
   logic              w_udf_set;
   logic [ADDR_W:0]   w_count_nxt;

   // Accept decisions from the registered flags; flush masks both requests.
   always_comb begin
      w_wr_acc    = wr_en & ~r_full  & ~flush;
      w_rd_acc    = rd_en & ~r_empty & ~flush;
      w_ovf_set   = wr_en &  r_full  & ~flush;
      w_udf_set   = rd_en &  r_empty & ~flush;
      w_count_nxt = r_count;
      if (flush) begin
         w_count_nxt = '0;
      end else if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + (ADDR_W+1)'(1);
      end else if (w_rd_acc && !w_wr_acc) begin
         w_count_nxt = r_count - (ADDR_W+1)'(1);
      end
   end

   // RAM write port; a write never targets the address being read.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers, occupancy and occupancy flags, all derived from the next count.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= 1'b0;
         r_aempty <= 1'b1;
      end else begin
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == c_depth);
         r_empty  <= (w_count_nxt == '0);
         r_afull  <= (w_count_nxt >= c_afull_th);
         r_aempty <= (w_count_nxt <= c_aempty_th);
      end
   end

   // Sticky error flags; a new error wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= w_ovf_set | (r_ovf & ~clr_flags);
         r_udf <= w_udf_set | (r_udf & ~clr_flags);
      end
   end

   generate
      if (READ_MODE == 0) begin : g_read_bypass
         // Single-cycle read: RAM output register drives dout directly.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_dout     <= '0;
               r_dout_vld <= 1'b0;
            end else begin
               r_dout_vld <= w_rd_acc;
               if (w_rd_acc) begin
                  r_dout <= r_mem[r_rd_ptr];
               end
            end
         end
      end else begin : g_read_pipe
         logic [DATA_W-1:0] r_ram_q;
         logic              r_ram_vld;

         // First stage: RAM read register, kept reset-free for RAM packing.
         always_ff @(posedge clk) begin
            if (w_rd_acc) begin
               r_ram_q <= r_mem[r_rd_ptr];
            end
         end

         // First-stage valid; cleared by reset or flush to cancel in-flight reads.
         always_ff @(posedge clk) begin
            if (reset || flush) begin
               r_ram_vld <= 1'b0;
            end else begin
               r_ram_vld <= w_rd_acc;
            end
         end

         // Output register: loads only on a valid stage-one word, else holds.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_dout     <= '0;
               r_dout_vld <= 1'b0;
            end else if (flush) begin
               r_dout_vld <= 1'b0;
            end else begin
               r_dout_vld <= r_ram_vld;
               if (r_ram_vld) begin
                  r_dout <= r_ram_q;
               end
            end
         end
      end
   endgenerate

   assign dout     = r_dout;
   assign dout_vld = r_dout_vld;
   assign count    = r_count;
   assign full     = r_full;
   assign empty    = r_empty;
   assign afull    = r_afull;
   assign aempty   = r_aempty;
   assign ovf      = r_ovf;
   assign udf      = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_sdpb_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdpb_sample_fifo
// Description : Scoreboard bench for sdpb_sample_fifo. Two instances (read
//               latency 1 and 2) share one random stimulus stream; a queue
//               model predicts occupancy/flags and the read data stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdpb_sample_fifo;

   localparam int DW    = 16;
   localparam int AW    = 11;
   localparam int DEPTH = 2 ** AW;
   localparam int AFT   = 1536;
   localparam int AET   = 512;

   typedef struct {
      int          due;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset, flush, wr_en, rd_en, clr_flags;
   logic [DW-1:0] din;

   logic [DW-1:0] dout0, dout1;
   logic          vld0, vld1;
   logic          full0, empty0, afull0, aempty0, ovf0, udf0;
   logic          full1, empty1, afull1, aempty1, ovf1, udf1;
   logic [AW:0]   count0, count1;

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   bit            rst_edge = 1'b1;

   // reference model state
   logic [DW-1:0] mq[$];
   bit            m_ovf = 1'b0;
   bit            m_udf = 1'b0;
   exp_t          expq [2][$];
   logic [DW-1:0] last_dout [2];

   always #5 clk = ~clk;

   sdpb_sample_fifo #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(0),
                      .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .din(din),
      .rd_en(rd_en), .dout(dout0), .dout_vld(vld0), .full(full0),
      .empty(empty0), .afull(afull0), .aempty(aempty0), .count(count0),
      .ovf(ovf0), .udf(udf0), .clr_flags(clr_flags));

   sdpb_sample_fifo #(.DATA_W(DW), .ADDR_W(AW), .READ_MODE(1),
                      .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .din(din),
      .rd_en(rd_en), .dout(dout1), .dout_vld(vld1), .full(full1),
      .empty(empty1), .afull(afull1), .aempty(aempty1), .count(count1),
      .ovf(ovf1), .udf(udf1), .clr_flags(clr_flags));

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= reset;
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, req);
      end
   endfunction

   // Output-side monitor: pops the scoreboard whenever a strobe appears.
   task automatic mon(input int k, input logic vld, input logic [DW-1:0] dat);
      exp_t e;
      if (rst_edge) begin
         chk($sformatf("rst_vld%0d", k), 32'(vld), 32'd0);
         chk($sformatf("rst_dout%0d", k), 32'(dat), 32'd0);
         last_dout[k] = '0;
      end else if (vld) begin
         if (expq[k].size() == 0) begin
            chk($sformatf("unexpected_vld%0d", k), 32'd1, 32'd0);
         end else begin
            e = expq[k].pop_front();
            chk($sformatf("vld_cycle%0d", k), 32'(cyc), 32'(e.due));
            chk($sformatf("dout%0d", k), 32'(dat), 32'(e.data));
            last_dout[k] = e.data;
         end
      end else begin
         chk($sformatf("hold%0d", k), 32'(dat), 32'(last_dout[k]));
         if (expq[k].size() > 0 && expq[k][0].due <= cyc) begin
            chk($sformatf("missing_vld%0d", k), 32'd0, 32'd1);
            void'(expq[k].pop_front());
         end
      end
   endtask

   // Monitor process, sampling on the falling edge.
   always @(negedge clk) begin
      mon(0, vld0, dout0);
      mon(1, vld1, dout1);
   end

   function automatic logic [31:0] model_state();
      int sz = mq.size();
      return 32'({12'(sz), sz == DEPTH, sz == 0, sz >= AFT, sz <= AET, m_ovf, m_udf});
   endfunction

   task automatic check_state();
      chk("state0", 32'({count0, full0, empty0, afull0, aempty0, ovf0, udf0}), model_state());
      chk("state1", 32'({count1, full1, empty1, afull1, aempty1, ovf1, udf1}), model_state());
   endtask

   task automatic cancel_pending();
      for (int k = 0; k < 2; k++)
         while (expq[k].size() > 0 && expq[k][$].due > cyc) void'(expq[k].pop_back());
   endtask

   // One clock of stimulus: check current state, drive, advance the model.
   task automatic step(input bit we, input bit re, input bit fl, input bit rs,
                       input bit cf, input logic [DW-1:0] d);
      int            sz;
      logic [DW-1:0] w;
      check_state();
      wr_en = we; rd_en = re; flush = fl; reset = rs; clr_flags = cf; din = d;
      sz = mq.size();
      if (rs) begin
         mq.delete(); m_ovf = 1'b0; m_udf = 1'b0;
         cancel_pending();
      end else if (fl) begin
         mq.delete();
         if (cf) begin m_ovf = 1'b0; m_udf = 1'b0; end
         cancel_pending();
      end else begin
         if (re && sz > 0) begin
            w = mq.pop_front();
            expq[0].push_back('{cyc + 1, w});
            expq[1].push_back('{cyc + 2, w});
         end
         if (we && sz < DEPTH) mq.push_back(d);
         m_ovf = (we && sz == DEPTH) || (m_ovf && !cf);
         m_udf = (re && sz == 0)     || (m_udf && !cf);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [DW-1:0] d); step(1, 0, 0, 0, 0, d); endtask
   task automatic rd();                       step(0, 1, 0, 0, 0, '0); endtask
   task automatic idle();                     step(0, 0, 0, 0, 0, '0); endtask

   initial begin
      reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      clr_flags = 1'b0; din = '0;
      last_dout[0] = '0; last_dout[1] = '0;
      @(negedge clk);
      step(0, 0, 0, 1, 0, '0);
      idle();

      // Four writes then four back-to-back reads.
      for (int i = 1; i <= 4; i++) wr(16'(i));
      for (int i = 0; i < 4; i++) rd();
      idle(); idle();

      // Three words, four reads: last read underflows, then clear.
      for (int i = 0; i < 3; i++) wr(16'($urandom));
      for (int i = 0; i < 4; i++) rd();
      idle(); idle();
      step(0, 0, 0, 0, 1, '0);

      // Fill to full, one rejected write, clear overflow.
      for (int i = 0; i < DEPTH; i++) wr(16'($urandom));
      wr(16'hDEAD);
      idle();
      step(0, 0, 0, 0, 1, '0);

      // Drain to 1000 then stream through for 5000 cycles (pointers wrap).
      for (int i = 0; i < DEPTH - 1000; i++) rd();
      for (int i = 0; i < 5000; i++) step(1, 1, 0, 0, 0, 16'($urandom));

      // Random traffic, read-leaning, with occasional flush and clear.
      for (int i = 0; i < 2000; i++) begin
         bit fl = ($urandom_range(0, 199) == 0);
         step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 60, fl, 0,
              !fl && ($urandom_range(0, 49) == 0), 16'($urandom));
      end
      for (int i = 0; i < 500; i++)
         step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30, 0, 0, 0,
              16'($urandom));

      // Flush with a read in flight.
      step(0, 0, 1, 0, 0, '0);
      for (int i = 0; i < 100; i++) wr(16'($urandom));
      rd();
      step(0, 0, 1, 0, 0, '0);
      idle(); idle(); idle();

      // Full with overflow, a read in flight, then reset.
      for (int i = 0; i < DEPTH; i++) wr(16'($urandom));
      wr(16'hBEEF);
      rd();
      step(0, 0, 0, 1, 0, '0);
      idle(); idle(); idle();

      check_state();
      chk("leftover0", 32'(expq[0].size()), 32'd0);
      chk("leftover1", 32'(expq[1].size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
